mont_modexp_ctrl: RTL

Sequencer that computes a modular exponentiation by driving one shared Montgomery multiplier with left-to-right square-and-multiply. It accepts a Montgomery-form base, the Montgomery-form one (R mod M), an exponent and an odd modulus. It issues one multiply at a time and returns the result with a done pulse. It sits between the host-side command logic and the montgomery multiplier datapath, which has operand inputs plus a start/done pair.

---
 rtl/mont_modexp_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Optional MODEXP_FROM_MONT_EN adds a final MM(acc, 1) to return the result in normal form.
module mont_modexp_ctrl #(
    parameter int W  = 12,
    parameter int EW = 12,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base_m,
    input  logic [W-1:0]  one_m,
    input  logic [EW-1:0] exp,
    input  logic [W-1:0]  mod_m,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic          mm_start,
    output logic [W-1:0]  mm_x,
    output logic [W-1:0]  mm_y,
    output logic [W-1:0]  mm_m,
    input  logic [W-1:0]  mm_s,
    input  logic          mm_done
);

    typedef enum logic [3:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        NEXT,
`ifdef MODEXP_FROM_MONT_EN
        CONV_ISSUE,
        CONV_WAIT,
`endif
        FINISH
    } state_t;

    state_t        state_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  base_q;
    logic [EW-1:0] exp_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [W-1:0]  result_q;
    logic          mm_start_q;
    logic [W-1:0]  mm_x_q;
    logic [W-1:0]  mm_y_q;
    logic [W-1:0]  mm_m_q;

    assign idx_d = idx_q - IW'(1);

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;
    assign mm_start = mm_start_q;
    assign mm_x     = mm_x_q;
    assign mm_y     = mm_y_q;
    assign mm_m     = mm_m_q;

    // Operands are loaded on the transition into each *_ISSUE state so
    // mm_start and its operands appear together and stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            base_q     <= '0;
            exp_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            mm_m_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mod_m[0]) begin
                            base_q     <= base_m;
                            exp_q      <= exp;
                            acc_q      <= one_m;
                            idx_q      <= IW'(EW - 1);
                            busy_q     <= 1'b1;
                            mm_start_q <= 1'b1;
                            mm_x_q     <= one_m;
                            mm_y_q     <= one_m;
                            mm_m_q     <= mod_m;
                            state_q    <= SQ_ISSUE;
                        end else begin
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            result_q <= '0;
                            state_q  <= FINISH;
                        end
                    end
                end
                SQ_ISSUE: begin
                    mm_start_q <= 1'b0;
                    state_q    <= SQ_WAIT;
                end
                SQ_WAIT: begin
                    if (mm_done) begin
                        acc_q <= mm_s;
                        if (exp_q[idx_q]) begin
                            mm_start_q <= 1'b1;
                            mm_x_q     <= mm_s;
                            mm_y_q     <= base_q;
                            state_q    <= MUL_ISSUE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                MUL_ISSUE: begin
                    mm_start_q <= 1'b0;
                    state_q    <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mm_done) begin
                        acc_q   <= mm_s;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == '0) begin
`ifdef MODEXP_FROM_MONT_EN
                        mm_start_q <= 1'b1;
                        mm_x_q     <= acc_q;
                        mm_y_q     <= W'(1);
                        state_q    <= CONV_ISSUE;
`else
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        result_q <= acc_q;
                        state_q  <= FINISH;
`endif
                    end else begin
                        idx_q      <= idx_d;
                        mm_start_q <= 1'b1;
                        mm_x_q     <= acc_q;
                        mm_y_q     <= acc_q;
                        state_q    <= SQ_ISSUE;
                    end
                end
`ifdef MODEXP_FROM_MONT_EN
                CONV_ISSUE: begin
                    mm_start_q <= 1'b0;
                    state_q    <= CONV_WAIT;
                end
                CONV_WAIT: begin
                    if (mm_done) begin
                        acc_q    <= mm_s;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        result_q <= mm_s;
                        state_q  <= FINISH;
                    end
                end
`endif
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
